// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instruction addresses must land on a word boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-issue instruction fetch with output slot, stall, redirect and halt
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              IMEM_WORDS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  // First byte address past the end of instruction memory.
  localparam logic [XLEN-1:0] FETCH_LIMIT = XLEN'(IMEM_WORDS * INSTR_BYTES);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(INSTR_BYTES);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;

  logic accept;
  logic slot_free;
  logic in_range;
  logic target_ok;

  // The memory is combinational, so the PC register drives it directly.
  assign imem_addr = pc;

  // Handshake and load-qualification terms shared by the sequential block.
  always_comb begin
    accept    = out_valid && out_ready;
    slot_free = !out_valid || out_ready;
    in_range  = (pc < FETCH_LIMIT);
    target_ok = is_aligned(redirect_pc);
  end

  // FSM, PC register, output slot, sticky error flag and handshake counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      // Every accepted handshake counts, including one coinciding with a flush.
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        IDLE: begin
          // Redirect while idle only repositions the PC; nothing is fetched yet.
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (start) begin
            state <= RUN;
          end
        end

        RUN, HALT: begin
          if (redirect_valid) begin
            // Redirect outranks load and stall; the slot is flushed either way.
            out_valid <= 1'b0;
            if (target_ok) begin
              pc     <= redirect_pc;
              state  <= RUN;
              halted <= 1'b0;
            end else begin
              misalign_err <= 1'b1;
              state        <= HALT;
              halted       <= 1'b1;
            end
          end else if (state == RUN) begin
            if (slot_free) begin
              if (in_range) begin
                out_instr <= imem_data;
                out_pc    <= pc;
                out_valid <= 1'b1;
                pc        <= pc + PC_STEP;
              end else begin
                // Ran off the end of memory: last word drained, stop fetching.
                out_valid <= 1'b0;
                state     <= HALT;
                halted    <= 1'b1;
              end
            end
            // Otherwise decode is stalling: hold pc and the output slot.
          end else begin
            // Halted: let a pending instruction drain, then empty the slot.
            if (accept) begin
              out_valid <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed and random stimulus
module tb_fetch_unit;

  localparam int          WORDS = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] LIM   = 32'd16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:WORDS-1];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;
  txn_t sbq[$];

  // reference model state
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_opc;
  logic [31:0] m_oinstr;
  logic [31:0] m_count;
  logic        m_err;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[3:2]];

  fetch_unit #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every presented handshake is compared against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_handshake", 32'd1, 32'd0);
        end else begin
          txn_t t;
          t = sbq.pop_front();
          check("hs_pc", out_pc, t.pc);
          check("hs_instr", out_instr, t.instr);
        end
      end
    end
  end

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_pc     = RPC;
    m_valid  = 1'b0;
    m_opc    = '0;
    m_oinstr = '0;
    m_count  = '0;
    m_err    = 1'b0;
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
  endtask

  // apply one cycle of inputs, predict its effect, then let the edge happen
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    txn_t t;
    start          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (m_valid && rdy) begin
      t.pc    = m_opc;
      t.instr = m_oinstr;
      sbq.push_back(t);
      m_count = m_count + 32'd1;
    end
    if (m_mode == M_IDLE) begin
      if (rv) m_pc = rpc;
      if (st) m_mode = M_RUN;
    end else if (rv) begin
      m_valid = 1'b0;
      if (rpc[1:0] == 2'b00) begin
        m_pc   = rpc;
        m_mode = M_RUN;
      end else begin
        m_err  = 1'b1;
        m_mode = M_HALT;
      end
    end else if (m_mode == M_RUN) begin
      if (!m_valid || rdy) begin
        if (m_pc < LIM) begin
          m_opc    = m_pc;
          m_oinstr = mem[m_pc[3:2]];
          m_valid  = 1'b1;
          m_pc     = m_pc + 32'd4;
        end else begin
          m_valid = 1'b0;
          m_mode  = M_HALT;
        end
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("pc", imem_addr, m_pc);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, (m_mode == M_HALT)});
  endtask

  task automatic do_reset(input logic st, input logic rv, input logic [31:0] rpc);
    rst_n          = 1'b0;
    start          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_imem_addr", imem_addr, RPC);
  endtask

  initial begin
    logic [31:0] tgt;
    logic        rv;
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    mem[0] = 32'h003100B3; mem[1] = 32'h00308233; mem[2] = 32'h401202B3; mem[3] = 32'h00000013;
    @(posedge clk); #1;

    // streaming to the fetch limit
    do_reset(1'b0, 1'b0, 32'd0);
    check_reset_values();
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("stream0_instr", out_instr, 32'h003100B3);
    check("stream0_pc", out_pc, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("stream1_instr", out_instr, 32'h00308233);
    check("stream1_pc", out_pc, 32'd4);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("stream2_instr", out_instr, 32'h401202B3);
    check("stream2_pc", out_pc, 32'd8);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("stream_count3", fetch_count, 32'd3);
    check("limit_last_pc", out_pc, 32'd12);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("limit_halted", {31'd0, halted}, 32'd1);
    check("limit_valid", {31'd0, out_valid}, 32'd0);
    check("limit_count4", fetch_count, 32'd4);

    // stall after first output
    do_reset(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_instr", out_instr, 32'h003100B3);
      check("stall_pc", out_pc, 32'd0);
      check("stall_addr", imem_addr, 32'd4);
      step(1'b0, 1'b0, 32'd0, 1'b0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("release_instr", out_instr, 32'h00308233);
    check("release_pc", out_pc, 32'd4);

    // redirect during a stall, then a misaligned redirect
    do_reset(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'd8, 1'b0);
    check("redir_flush", {31'd0, out_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("redir_pc", out_pc, 32'd8);
    check("redir_instr", out_instr, 32'h401202B3);
    step(1'b0, 1'b1, 32'd6, 1'b0);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_pc_kept", imem_addr, 32'd12);
    step(1'b0, 1'b1, 32'd0, 1'b1);
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // reset while stalled with a redirect and start also asserted
    do_reset(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    do_reset(1'b1, 1'b1, 32'd8);
    check_reset_values();

    // randomized traffic against the reference model
    fill_mem_random();
    do_reset(1'b0, 1'b0, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        fill_mem_random();
        do_reset($urandom_range(0, 1) == 1, 1'b0, 32'd0);
      end else begin
        tgt = 32'($urandom_range(0, 5)) * 32'd4;
        if (m_mode != M_IDLE && $urandom_range(0, 7) == 0) tgt = tgt + 32'($urandom_range(1, 3));
        rv = ($urandom_range(0, 9) == 0);
        step($urandom_range(0, 3) == 0, rv, tgt, $urandom_range(0, 9) < 7);
      end
    end
    step(1'b0, 1'b0, 32'd0, 1'b0);
    check("final_queue_empty", 32'(sbq.size()), 32'd0);
    check("final_fetch_count", fetch_count, m_count);
    check("final_misalign", {31'd0, misalign_err}, {31'd0, m_err});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded at reset.
REQ-002 Parameter IMEM_WORDS, default 16, SHALL be the instruction memory depth in 32-bit words; the fetch limit is IMEM_WORDS*4 bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 start  input  1  SHALL be the level/pulse that moves the unit from IDLE to RUN.
REQ-006 imem_addr  output  32  SHALL be the byte address presented to the combinational instruction memory.
REQ-007 imem_data  input  32  SHALL be the instruction word returned for imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  SHALL request a PC change (branch/jump).
REQ-009 redirect_pc  input  32  SHALL be the target byte address, sampled when redirect_valid=1.
REQ-010 out_valid  output  1  SHALL indicate that out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  SHALL indicate that decode accepts the output this cycle.
REQ-012 out_instr  output  32  SHALL be the fetched instruction word.
REQ-013 out_pc  output  32  SHALL be the byte address of out_instr.
REQ-014 halted  output  1  SHALL be high while the state is HALT.
REQ-015 misalign_err  output  1  SHALL be a sticky flag for a redirect target with bits [1:0]≠0.
REQ-016 fetch_count  output  32  SHALL count accepted handshakes (out_valid && out_ready).

Function
REQ-017 imem_addr SHALL equal the PC register combinationally at all times.
REQ-018 The FSM SHALL have states IDLE, RUN and HALT.
- IDLE→RUN when start=1.
- RUN→HALT on the fetch-limit condition or on a misaligned redirect.
- HALT→RUN only on an aligned redirect.
REQ-019 In RUN, load SHALL be (!out_valid || out_ready) && pc < IMEM_WORDS*4.
- On load: out_instr←imem_data, out_pc←pc, out_valid←1, pc←pc+4 (mod 2^32).
- The result is one instruction per cycle with no bubbles while out_ready=1.
REQ-020 In RUN, when out_valid=1 and out_ready=0, pc, out_instr and out_pc SHALL hold (stall).
REQ-021 In RUN, when pc ≥ IMEM_WORDS*4 and the slot is free or being drained, no load SHALL occur and the state SHALL go to HALT.
- A pending out_valid SHALL remain until accepted, then clear.
REQ-022 An aligned redirect_valid in RUN or HALT SHALL have priority over load and stall.
- Effects: pc←redirect_pc, out_valid←0 (flush), state←RUN.
- The first fetch from the target occurs the following cycle (1-cycle redirect penalty).
REQ-023 A redirect_valid in IDLE SHALL update pc only; the state stays IDLE and out_valid stays 0.
REQ-024 A misaligned redirect SHALL set misalign_err=1, leave pc unchanged, flush out_valid and go to HALT.
- misalign_err clears only on reset.
REQ-025 fetch_count SHALL increment on every cycle with out_valid && out_ready, including a redirect cycle, and SHALL wrap at 2^32.
REQ-026 In IDLE and HALT no load SHALL occur.
- In HALT, out_valid SHALL clear once accepted.

Reset
REQ-027 When rst_n=0 at a rising edge, the following SHALL be set regardless of all other inputs, including mid-stall and mid-redirect:
- pc=RESET_PC, state=IDLE
- out_valid=0, out_instr=0, out_pc=0
- halted=0, misalign_err=0, fetch_count=0
REQ-028 The first load after reset SHALL occur no earlier than the cycle after start is sampled high.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum (IDLE/RUN/HALT), XLEN=32, INSTR_BYTES=4 and the default RESET_PC.
REQ-030 No sub-module SHALL be used; the PC register, the FSM and the output register reside in fetch_unit, and the instruction memory is instantiated alongside it at the top level.

Verification
REQ-031 The bench SHALL cover the following scenarios.
- Streaming: imem word0=0x003100B3, word1=0x00308233, word2=0x401202B3; reset, start, out_ready=1. Expect out_instr 0x003100B3/0x00308233/0x401202B3 with out_pc 0/4/8 on consecutive cycles, and fetch_count=3.
- Stall: out_ready=0 for 3 cycles after the first output. Expect out_instr=0x003100B3, out_pc=0 held and imem_addr=4 constant; on release, 0x00308233 follows the next cycle.
- Fetch limit: IMEM_WORDS=4, out_ready=1. Expect 4 outputs (out_pc 0..12), then halted=1 with out_valid=0 and fetch_count=4.
- Redirect in the same cycle as a stall: redirect_pc=8. Expect out_valid=0 the next cycle, then out_pc=8 with out_instr=0x401202B3. In a second case, redirect_pc=6 gives misalign_err=1, halted=1 and pc unchanged.
- Mid-stream reset: drop rst_n while out_valid=1 and stalled. Expect all outputs at reset values the next cycle, and imem_addr=RESET_PC.
